// File: rtl/rng_arbiter.sv
// ---------------------------------------------------------------------------
// rng_arbiter
//
// Round-robin arbiter that shares one 16-bit random generator between
// NUM_REQ requesters.
//
// Per transaction it:
//   1. picks one requester,
//   2. pulses the generator enable for one cycle,
//   3. waits for the generator's done level,
//   4. returns the captured value to the winner with a one-hot valid pulse.
//
// It is the only block that drives the generator enable.
//
// Ports:
//   clock      : system clock, all state on the rising edge
//   nrst       : synchronous active-low reset
//   req        : per-requester level request, held until its rsp_valid bit
//   gnt        : one-hot grant, held from ISSUE through RESP
//   rsp_valid  : one-hot, one-cycle response pulse to the granted requester
//   rsp_data   : captured random value, held until the next response
//   rsp_err    : timeout flag, qualified by rsp_valid
//   busy       : high whenever the arbiter is not idle
//   rng_en     : one-cycle enable pulse to the generator
//   rng_done   : generator done level (cleared when it accepts rng_en)
//   rng_data   : generator output value
//
// Optional feature macro: RNG_ARB_TIMEOUT_EN
//   Defined    : WAIT gives up after TIMEOUT cycles and responds with
//                rsp_data=0 and rsp_err=1.
//   Undefined  : WAIT holds until rng_done, and rsp_err is constant 0.
// ---------------------------------------------------------------------------
module rng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               nrst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               rng_en,
  input  logic               rng_done,
  input  logic [15:0]        rng_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [PTR_W-1:0]   winner_r, winner_nxt_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_nxt_s;
  logic [15:0]        rsp_data_r, rsp_data_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               rng_en_r, rng_en_nxt_s;
  logic [PTR_W-1:0]   pick_s;

`ifdef RNG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic               rsp_err_r, rsp_err_nxt_s;
`endif

  // Search start, start+1, ... with wrap-around; the first set bit wins.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req_v,
    input logic [PTR_W-1:0]   ptr
  );
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_v[idx]) begin
        pick  = idx[PTR_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Expands a requester index into a one-hot vector.
  function automatic logic [NUM_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (i == int'(idx));
    end
    return oh;
  endfunction

  // Winner for the current request vector, meaningful only in IDLE.
  always_comb begin
    pick_s = rr_pick(req, rr_ptr_r);
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    winner_nxt_s    = winner_r;
    gnt_nxt_s       = gnt_r;
    rsp_valid_nxt_s = {NUM_REQ{1'b0}};
    rsp_data_nxt_s  = rsp_data_r;
`ifdef RNG_ARB_TIMEOUT_EN
    wait_cnt_nxt_s  = wait_cnt_r;
    rsp_err_nxt_s   = rsp_err_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (req != {NUM_REQ{1'b0}}) begin
          winner_nxt_s = pick_s;
          gnt_nxt_s    = one_hot(pick_s);
          state_nxt_s  = ST_ISSUE;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        state_nxt_s    = ST_WAIT;
`ifdef RNG_ARB_TIMEOUT_EN
        wait_cnt_nxt_s = {CNT_W{1'b0}};
`endif
      end

      ST_WAIT: begin
        if (rng_done) begin
          rsp_data_nxt_s  = rng_data;
          rsp_valid_nxt_s = gnt_r;
          state_nxt_s     = ST_RESP;
`ifdef RNG_ARB_TIMEOUT_EN
          rsp_err_nxt_s   = 1'b0;
        end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          // This WAIT cycle is the TIMEOUT-th one without done: give up.
          rsp_data_nxt_s  = 16'h0000;
          rsp_err_nxt_s   = 1'b1;
          rsp_valid_nxt_s = gnt_r;
          state_nxt_s     = ST_RESP;
        end else begin
          wait_cnt_nxt_s  = wait_cnt_r + CNT_W'(1);
          state_nxt_s     = ST_WAIT;
        end
`else
        end else begin
          state_nxt_s     = ST_WAIT;
        end
`endif
      end

      ST_RESP: begin
        if (winner_r == PTR_W'(NUM_REQ - 1)) begin
          rr_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
          rr_ptr_nxt_s = winner_r + PTR_W'(1);
        end
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        state_nxt_s = ST_IDLE;
      end

      default: begin
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase

    // The enable and busy flags are registered from the next state, so
    // rng_en is high exactly while the state is ISSUE.
    rng_en_nxt_s = (state_nxt_s == ST_ISSUE);
    busy_nxt_s   = (state_nxt_s != ST_IDLE);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {PTR_W{1'b0}};
      winner_r    <= {PTR_W{1'b0}};
      gnt_r       <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_data_r  <= 16'h0000;
      busy_r      <= 1'b0;
      rng_en_r    <= 1'b0;
`ifdef RNG_ARB_TIMEOUT_EN
      wait_cnt_r  <= {CNT_W{1'b0}};
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      winner_r    <= winner_nxt_s;
      gnt_r       <= gnt_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      busy_r      <= busy_nxt_s;
      rng_en_r    <= rng_en_nxt_s;
`ifdef RNG_ARB_TIMEOUT_EN
      wait_cnt_r  <= wait_cnt_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
`endif
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign rng_en    = rng_en_r;
`ifdef RNG_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_r;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_arbiter
//
// Self-checking bench for rng_arbiter.
//
// A small LFSR generator model (seed 5) answers the rng_en/rng_done
// handshake with a configurable latency.
//
// The reference model tracks two things:
//   - the round-robin pointer as a plain integer, from which it derives the
//     expected winner;
//   - the expected data stream as successive LFSR values.
// ---------------------------------------------------------------------------
module tb_rng_arbiter;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          nrst  = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          rng_en;
  logic          rng_done;
  logic [15:0]   rng_data;

  int vectors    = 0;
  int miscompares = 0;
  int overlap    = 0;

  // Reference model state.
  int          model_ptr  = 0;
  logic [15:0] model_lfsr = 16'h0005;

  // Generator model state.
  logic [15:0] gen_lfsr;
  int          gen_cnt;
  int          gen_lat = 2;
  bit          stall   = 1'b0;

  rng_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clock     (clock),
    .nrst      (nrst),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .rng_en    (rng_en),
    .rng_done  (rng_done),
    .rng_data  (rng_data)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ s[2]};
  endfunction

  // Generator: enable clears done; done rises gen_lat cycles later with a new value.
  always @(posedge clock) begin
    if (!nrst) begin
      gen_lfsr <= 16'h0005;
      rng_done <= 1'b0;
      gen_cnt  <= 0;
    end else if (rng_en) begin
      rng_done <= 1'b0;
      gen_cnt  <= gen_lat;
    end else if (gen_cnt != 0) begin
      gen_cnt <= gen_cnt - 1;
      if (gen_cnt == 1 && !stall) begin
        rng_done <= 1'b1;
        gen_lfsr <= lfsr_next(gen_lfsr);
      end
    end
  end
  assign rng_data = gen_lfsr;

  // Grant must never have more than one bit set.
  always @(negedge clock) begin
    if ($countones(gnt) > 1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    req  = '0;
    step();
    step();
    check({tag, " rst gnt"},       gnt,       32'h0);
    check({tag, " rst rsp_valid"}, rsp_valid, 32'h0);
    check({tag, " rst rsp_data"},  rsp_data,  32'h0);
    check({tag, " rst rsp_err"},   rsp_err,   32'h0);
    check({tag, " rst busy"},      busy,      32'h0);
    check({tag, " rst rng_en"},    rng_en,    32'h0);
    nrst       = 1'b1;
    model_ptr  = 0;
    model_lfsr = 16'h0005;
  endtask

  // Serve one transaction: predict winner and data, wait (bounded), compare.
  // If drop_after > 0, the winner drops its req that many cycles in.
  task automatic wait_resp(input string tag, input int drop_after, output int cyc);
    int         exp_w;
    int         idx;
    bit         seen;
    logic [N-1:0] exp_oh;
    exp_w = -1;
    for (int i = 0; i < N; i++) begin
      idx = (model_ptr + i) % N;
      if (exp_w < 0 && req[idx]) exp_w = idx;
    end
    if (exp_w < 0) exp_w = 0;
    exp_oh     = N'(1) << exp_w;
    model_lfsr = lfsr_next(model_lfsr);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 30) begin
      step();
      cyc++;
      if (rsp_valid != '0) seen = 1'b1;
      if (cyc == drop_after) req[exp_w] = 1'b0;
    end
    check({tag, " seen"},      seen,      32'h1);
    check({tag, " rsp_valid"}, rsp_valid, exp_oh);
    check({tag, " gnt"},       gnt,       exp_oh);
    check({tag, " rsp_data"},  rsp_data,  model_lfsr);
    check({tag, " rsp_err"},   rsp_err,   32'h0);
    req[exp_w] = 1'b0;
    model_ptr  = (exp_w + 1) % N;
  endtask

  initial begin
    int cyc;
    int seen_cnt;

    // ---- reset state and single-request latency ----
    do_reset("t0");
    req = 4'b0001;
    step();
    check("t1 e0 gnt",     gnt,    32'h1);
    check("t1 e0 rng_en",  rng_en, 32'h1);
    check("t1 e0 busy",    busy,   32'h1);
    step();
    check("t1 e1 rng_en",  rng_en, 32'h0);
    check("t1 e1 gnt",     gnt,    32'h1);
    step();
    check("t1 e2 rsp_valid", rsp_valid, 32'h0);
    step();
    check("t1 e3 rsp_valid", rsp_valid, 32'h0);
    step();
    check("t1 e4 rsp_valid", rsp_valid, 32'h1);
    check("t1 e4 rsp_data",  rsp_data,  32'h000B);
    check("t1 e4 rsp_err",   rsp_err,   32'h0);
    req = 4'b0000;
    step();
    check("t1 e5 rsp_valid", rsp_valid, 32'h0);
    check("t1 e5 gnt",       gnt,       32'h0);
    check("t1 e5 busy",      busy,      32'h0);
    check("t1 e5 hold data", rsp_data,  32'h000B);
    model_ptr  = 1;
    model_lfsr = 16'h000B;
    req = 4'b0001;
    wait_resp("t1b", 0, cyc);
    check("t1b data const", rsp_data, 32'h0016);
    check("t1b latency",    cyc,      32'd5);

    // ---- all four request, served 0,1,2,3 back to back ----
    do_reset("t2");
    req = 4'b1111;
    wait_resp("t2 r0", 0, cyc);
    check("t2 r0 data", rsp_data, 32'h000B);
    for (int k = 1; k < N; k++) begin
      wait_resp("t2 rn", 0, cyc);
      check("t2 b2b period", cyc, 32'd6);
    end
    check("t2 r3 gnt", gnt, 32'h8);

    // ---- skip-over and wrap-around ----
    do_reset("t3");
    req = 4'b1010;
    wait_resp("t3 a", 0, cyc);
    check("t3 a winner", rsp_valid, 32'h2);
    wait_resp("t3 b", 0, cyc);
    check("t3 b winner", rsp_valid, 32'h8);
    req = 4'b0010;
    wait_resp("t3 c", 0, cyc);
    check("t3 c winner", rsp_valid, 32'h2);

    // ---- reset while in WAIT ----
    req = 4'b0001;
    step();
    step();
    nrst = 1'b0;
    req  = 4'b0000;
    step();
    check("t4 gnt",       gnt,       32'h0);
    check("t4 rsp_valid", rsp_valid, 32'h0);
    check("t4 rsp_data",  rsp_data,  32'h0);
    check("t4 busy",      busy,      32'h0);
    check("t4 rng_en",    rng_en,    32'h0);
    step();
    check("t4 no resp",   rsp_valid, 32'h0);
    nrst       = 1'b1;
    model_ptr  = 0;
    model_lfsr = 16'h0005;
    step();
    req = 4'b0001;
    wait_resp("t4 after", 0, cyc);
    check("t4 after data", rsp_data, 32'h000B);

    // ---- requester drops req during WAIT ----
    req = 4'b0100;
    wait_resp("t5", 2, cyc);
    step();
    check("t5 busy",      busy,      32'h0);
    check("t5 rsp_valid", rsp_valid, 32'h0);

    // ---- generator never finishes ----
    do_reset("t6");
    stall = 1'b1;
    req   = 4'b0001;
`ifdef RNG_ARB_TIMEOUT_EN
    cyc = 0;
    seen_cnt = 0;
    while (seen_cnt == 0 && cyc < 40) begin
      step();
      cyc++;
      if (rsp_valid != '0) seen_cnt++;
    end
    check("t6 seen",      seen_cnt,  32'd1);
    check("t6 latency",   cyc,       32'd17);
    check("t6 rsp_valid", rsp_valid, 32'h1);
    check("t6 rsp_err",   rsp_err,   32'h1);
    check("t6 rsp_data",  rsp_data,  32'h0);
`else
    seen_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rsp_valid != '0) seen_cnt++;
    end
    check("t6 no resp", seen_cnt, 32'd0);
    check("t6 busy",    busy,     32'h1);
    check("t6 gnt",     gnt,      32'h1);
    check("t6 rsp_err", rsp_err,  32'h0);
`endif
    stall = 1'b0;

    // ---- randomized requests and generator latency ----
    do_reset("t7");
    for (int t = 0; t < 30; t++) begin
      if (req == '0) req = N'($urandom_range(1, 15));
      gen_lat = $urandom_range(1, 5);
      wait_resp("t7 rand", 0, cyc);
      req = req | N'($urandom_range(0, 15));
    end
    req = '0;
    step();
    step();
    check("gnt overlap", overlap, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Round-robin arbiter that shares one 16-bit LFSR random generator (en_rng/done/rng_out handshake) between NUM_REQ requesters.
- Sequences the generator: issues a one-cycle enable, waits for done, captures the value and returns it to the granted requester with a one-hot valid pulse.
- Sits between game/datapath consumers and the generator; the only block allowed to drive the generator's enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 15, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clock  input  1  system clock; all state on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  level request per requester; held until its rsp_valid bit.
- gnt  output  NUM_REQ  one-hot grant; held from ISSUE through RESP.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester.
- rsp_data  output  16  captured random value; shared bus, held until the next RESP.
- rsp_err  output  1  timeout flag, valid with rsp_valid; tied 0 without the feature.
- busy  output  1  high in any state other than IDLE.
- rng_en  output  1  enable to the generator; one-cycle pulse.
- rng_done  input  1  generator done (a level; cleared by the generator on accepting enable).
- rng_data  input  16  generator output value.

Behaviour:
- Reset (nrst=0 at an edge): state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, rng_en=0, busy=0, rr_ptr=0, wait counter=0. Reset mid-transaction abandons the transaction with no response. The generator is reset on the same nrst.
- FSM:
  - IDLE: if req!=0, pick a winner, register gnt, go to ISSUE. Otherwise stay.
  - ISSUE: rng_en=1 for exactly this cycle; go to WAIT.
  - WAIT: rng_en=0.
    - If rng_done=1: rsp_data<=rng_data, rsp_err<=0, go to RESP.
    - Else stay.
    - rng_done is guaranteed 0 on the first WAIT cycle because the generator clears done when it accepts the enable.
  - RESP: rsp_valid=gnt for one cycle. At the edge: rr_ptr<=winner+1 mod NUM_REQ, gnt<=0, go to IDLE.
- Arbitration: round-robin starting at rr_ptr. Search rr_ptr, rr_ptr+1, … with wrap-around; the first set req bit wins. Only bits set in IDLE are considered.
- Latency: req sampled at edge E0 (in IDLE) → rng_en high E0..E1 → generator done after E3 → capture at E4 → rsp_valid high E4..E5 → IDLE after E5.
  - 5 cycles from request sample to rsp_valid.
  - A back-to-back transaction repeats every 6 cycles.
- Request rules:
  - A requester drops req in the cycle after its rsp_valid. If req is still high in the next IDLE, it is treated as a new request, subject to round-robin.
  - Dropping req after grant does not cancel the transaction; the response is still delivered.
- Simultaneous requests: only one is served per transaction; the others stay pending, and round-robin guarantees service within NUM_REQ transactions.
- The arbiter never asserts rng_en outside ISSUE. This guarantees the generator is in its idle state when enabled.
- rsp_data is 16 bits wide, unmodified from rng_data.

Optional Feature:
- Macro RNG_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with rng_done still 0: rsp_data<=0, rsp_err<=1, go to RESP.
  - rsp_err is otherwise 0.
- Not defined: no counter; WAIT holds indefinitely until rng_done; rsp_err is a constant 0.

Test Plan:
- Reset, then req=4'b0001 → gnt=0001, rng_en is a single-cycle pulse, rsp_valid=0001 five cycles after req sampling, rsp_data=16'h000B (first value from LFSR seed 5); a second request returns 16'h0016.
- req=4'b1111 held, each requester dropping req after its rsp_valid → grant order 0,1,2,3; rsp_data sequence 000B, 0016, then the next LFSR values; no overlap of gnt.
- req=4'b1010 with rr_ptr=0 → requester 1 served, then requester 3; then req=4'b0010 → requester 1 served again after wrap-around.
- nrst=0 asserted while in WAIT → next cycle all outputs 0, busy=0, no rsp_valid; a new req afterwards returns 16'h000B.
- Requester drops req during WAIT → rsp_valid is still pulsed to it with valid data; busy returns to 0 one cycle later.
- With RNG_ARB_TIMEOUT_EN and rng_done forced 0 → rsp_valid after TIMEOUT=15 WAIT cycles with rsp_err=1 and rsp_data=0. Without the macro, the arbiter remains in WAIT with busy=1.
